// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
// Word/byte widths, FSM state encoding, requester identifiers and the range check.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic SRC_P = 1'b0;
   localparam logic SRC_D = 1'b1;

   // A word occupies addr..addr+3; evaluated in 33 bits so addresses near 2^32 cannot wrap into range.
   function automatic logic addr_in_range(input logic [WORD_W-1:0] addr, input int unsigned depth);
      return ({1'b0, addr} + 33'd3) <= (33'(depth) - 33'd1);
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the two requesters, the access controller and the data memory.
// Handshake: a requester raises *_req with its command and holds all of it stable until the
// one-cycle p_done / d_ack pulse; read data and err are valid in that same cycle.
interface dmem_access_ctrl_if;
   import dmem_pkg::*;

   logic              p_req;
   logic              p_wr;
   logic [WORD_W-1:0] p_addr;
   logic [WORD_W-1:0] p_wdata;
   logic [WORD_W-1:0] p_rdata;
   logic              p_done;
   logic              p_stall;

   logic              d_req;
   logic              d_wr;
   logic [WORD_W-1:0] d_addr;
   logic [WORD_W-1:0] d_wdata;
   logic [WORD_W-1:0] d_rdata;
   logic              d_ack;

   logic              err;

   logic [WORD_W-1:0] mem_address;
   logic [WORD_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [WORD_W-1:0] mem_rdata;

   modport slave (
      input  p_req, p_wr, p_addr, p_wdata,
      input  d_req, d_wr, d_addr, d_wdata,
      input  mem_rdata,
      output p_rdata, p_done, p_stall,
      output d_rdata, d_ack,
      output err,
      output mem_address, mem_wdata, mem_read, mem_write
   );

   modport master (
      output p_req, p_wr, p_addr, p_wdata,
      output d_req, d_wr, d_addr, d_wdata,
      output mem_rdata,
      input  p_rdata, p_done, p_stall,
      input  d_rdata, d_ack,
      input  err,
      input  mem_address, mem_wdata, mem_read, mem_write
   );

endinterface

// File: rtl/dmem_rr_grant.sv
// Fixed-priority grant (pipeline first) with a starvation counter that forces the DMA port
// through after MAX_STARVE consecutive pipeline grants while it is waiting.
module dmem_rr_grant #(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arb_en,
   input  logic p_req,
   input  logic d_req,
   output logic gnt_p,
   output logic gnt_d
);

   localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

   logic [SW-1:0] starve_q;
   logic          force_d;

   assign force_d = d_req && (starve_q == STARVE_MAX);
   assign gnt_p   = arb_en && p_req && !force_d;
   assign gnt_d   = arb_en && d_req && !gnt_p;

   // A DMA port that drops its request owes nothing, so its starvation history is forgotten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else if (!d_req || gnt_d) begin
         starve_q <= '0;
      end else if (gnt_p && (starve_q != STARVE_MAX)) begin
         starve_q <= starve_q + SW'(1);
      end
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a byte-addressed big-endian word memory between the pipeline MEM stage and a DMA loader:
// registers the granted request, holds the strobes for ACC_CYCLES, then pulses done for one cycle.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH      = 101,
   parameter int ACC_CYCLES = 1,
   parameter int MAX_STARVE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   dmem_access_ctrl_if.slave   bus,
   output state_t              state_dbg
);

   localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              src_q;
   logic              wr_q;
   logic              err_q;
   logic [WORD_W-1:0] mem_addr_q;
   logic [WORD_W-1:0] mem_wdata_q;
   logic [WORD_W-1:0] p_rdata_q;
   logic [WORD_W-1:0] d_rdata_q;

   logic              gnt_p, gnt_d, any_gnt;
   logic              sel_wr, sel_ok;
   logic [WORD_W-1:0] sel_addr, sel_wdata;
   logic              p_done_w, d_ack_w;

   dmem_rr_grant #(
      .MAX_STARVE (MAX_STARVE)
   ) u_grant (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_en (state_q == IDLE),
      .p_req  (bus.p_req),
      .d_req  (bus.d_req),
      .gnt_p  (gnt_p),
      .gnt_d  (gnt_d)
   );

   assign any_gnt   = gnt_p | gnt_d;
   assign sel_wr    = gnt_d ? bus.d_wr    : bus.p_wr;
   assign sel_addr  = gnt_d ? bus.d_addr  : bus.p_addr;
   assign sel_wdata = gnt_d ? bus.d_wdata : bus.p_wdata;
   assign sel_ok    = addr_in_range(sel_addr, DEPTH);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (any_gnt) begin
               state_d = sel_ok ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         src_q       <= SRC_P;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         p_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (any_gnt) begin
                  src_q <= gnt_d ? SRC_D : SRC_P;
                  wr_q  <= sel_wr;
                  err_q <= ~sel_ok;
                  cnt_q <= CNT_INIT;
                  // Rejected accesses leave the memory-side registers untouched.
                  if (sel_ok) begin
                     mem_addr_q  <= sel_addr;
                     mem_wdata_q <= sel_wdata;
                  end else if (gnt_d) begin
                     d_rdata_q <= '0;
                  end else begin
                     p_rdata_q <= '0;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == '0) begin
                  if (src_q == SRC_D) begin
                     d_rdata_q <= wr_q ? '0 : bus.mem_rdata;
                  end else begin
                     p_rdata_q <= wr_q ? '0 : bus.mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes decode straight from the state register so an asynchronous reset drops them at once.
   assign bus.mem_read    = (state_q == ACCESS) && !wr_q;
   assign bus.mem_write   = (state_q == ACCESS) &&  wr_q;
   assign bus.mem_address = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;

   assign p_done_w    = (state_q == RESP) && (src_q == SRC_P);
   assign d_ack_w     = (state_q == RESP) && (src_q == SRC_D);
   assign bus.p_done  = p_done_w;
   assign bus.d_ack   = d_ack_w;
   assign bus.err     = (state_q == RESP) && err_q;
   assign bus.p_rdata = p_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.p_stall = bus.p_req && !p_done_w;

   assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, randomized accesses against a byte-array
// reference model, arbitration fairness, and asynchronous abort on a slow-memory instance.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int TB_DEPTH = 101;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n3 = 1'b0;
  logic mem_load = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl_if bus1 ();
  dmem_access_ctrl_if bus3 ();
  state_t state1, state3;

  dmem_access_ctrl #(.DEPTH(TB_DEPTH), .ACC_CYCLES(1), .MAX_STARVE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(state1)
  );

  dmem_access_ctrl #(.DEPTH(TB_DEPTH), .ACC_CYCLES(3), .MAX_STARVE(4)) dut3 (
    .clk(clk), .rst_n(rst_n3), .bus(bus3), .state_dbg(state3)
  );

  // ---------------- memory models ----------------
  logic [7:0] mem_b [0:TB_DEPTH-1];

  always_comb begin
    int base;
    base = int'(bus1.mem_address);
    bus1.mem_rdata = '0;
    if (bus1.mem_address <= 32'(TB_DEPTH - 4)) begin
      bus1.mem_rdata = {mem_b[base], mem_b[base+1], mem_b[base+2], mem_b[base+3]};
    end
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < TB_DEPTH; k++) mem_b[k] <= 8'(k);
    end else if (bus1.mem_write && (bus1.mem_address <= 32'(TB_DEPTH - 4))) begin
      for (int i = 0; i < 4; i++)
        mem_b[int'(bus1.mem_address) + i] <= bus1.mem_wdata[31-8*i -: 8];
    end
  end

  // Second instance sees a read-only memory where byte k holds k.
  always_comb begin
    logic [31:0] a;
    a = bus3.mem_address;
    bus3.mem_rdata = '0;
    if (a <= 32'(TB_DEPTH - 4)) bus3.mem_rdata = {8'(a), 8'(a + 1), 8'(a + 2), 8'(a + 3)};
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_b [0:TB_DEPTH-1];
  logic [31:0] exp_q[$];

  function automatic logic ref_oob(input logic [31:0] a);
    return (64'(a) + 64'd3) > 64'(TB_DEPTH - 1);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int b;
    b = int'(a);
    return {ref_b[b], ref_b[b+1], ref_b[b+2], ref_b[b+3]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] w);
    int b;
    b = int'(a);
    ref_b[b] = w[31:24]; ref_b[b+1] = w[23:16]; ref_b[b+2] = w[15:8]; ref_b[b+3] = w[7:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic src, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err_o, output int lat, output int rd_cyc,
                           output int wr_cyc, output logic side_ok, output logic ok);
    @(negedge clk);
    if (src == SRC_P) begin
      bus1.p_req = 1'b1; bus1.p_wr = wr; bus1.p_addr = addr; bus1.p_wdata = wdata;
    end else begin
      bus1.d_req = 1'b1; bus1.d_wr = wr; bus1.d_addr = addr; bus1.d_wdata = wdata;
    end
    lat = 0; rd_cyc = 0; wr_cyc = 0; side_ok = 1'b1; ok = 1'b0; rdata = '0; err_o = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bus1.mem_read) rd_cyc++;
      if (bus1.mem_write) wr_cyc++;
      if ((src == SRC_P) ? bus1.d_ack : bus1.p_done) side_ok = 1'b0;
      if ((src == SRC_P) ? bus1.p_done : bus1.d_ack) begin
        ok = 1'b1;
        rdata = (src == SRC_P) ? bus1.p_rdata : bus1.d_rdata;
        err_o = bus1.err;
        if (bus1.p_stall) side_ok = 1'b0;
      end else if (bus1.p_stall !== (src == SRC_P)) begin
        side_ok = 1'b0;
      end
    end
    bus1.p_req = 1'b0;
    bus1.d_req = 1'b0;
  endtask

  typedef struct {
    logic        src;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [31:0] r;
    logic e, side_ok, ok;
    int lat, rdc, wrc;
    int seq [$];
    int run;
    int n, dn, fired;

    vt[0] = '{SRC_P, 1'b0, 32'd8,          32'h0,        32'h08090A0B, 1'b0, 2};
    vt[1] = '{SRC_D, 1'b1, 32'd20,         32'hDEADBEEF, 32'h0,        1'b0, 2};
    vt[2] = '{SRC_D, 1'b0, 32'd20,         32'h0,        32'hDEADBEEF, 1'b0, 2};
    vt[3] = '{SRC_P, 1'b0, 32'd98,         32'h0,        32'h0,        1'b1, 1};
    vt[4] = '{SRC_P, 1'b0, 32'd97,         32'h0,        32'h61626364, 1'b0, 2};
    vt[5] = '{SRC_D, 1'b0, 32'd98,         32'h0,        32'h0,        1'b1, 1};
    vt[6] = '{SRC_P, 1'b1, 32'd0,          32'h11223344, 32'h0,        1'b0, 2};
    vt[7] = '{SRC_P, 1'b0, 32'd0,          32'h0,        32'h11223344, 1'b0, 2};
    vt[8] = '{SRC_D, 1'b0, 32'hFFFFFFFE,   32'h0,        32'h0,        1'b1, 1};
    vt[9] = '{SRC_P, 1'b0, 32'd16,         32'h0,        32'h10111213, 1'b0, 2};

    for (int k = 0; k < TB_DEPTH; k++) ref_b[k] = 8'(k);
    bus1.p_req = 0; bus1.p_wr = 0; bus1.p_addr = 0; bus1.p_wdata = 0;
    bus1.d_req = 0; bus1.d_wr = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
    bus3.p_req = 0; bus3.p_wr = 0; bus3.p_addr = 0; bus3.p_wdata = 0;
    bus3.d_req = 0; bus3.d_wr = 0; bus3.d_addr = 0; bus3.d_wdata = 0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state1), 32'(IDLE));
    chk("rst_strobes", {30'd0, bus1.mem_read, bus1.mem_write}, 32'd0);
    chk("rst_pulses", {29'd0, bus1.p_done, bus1.d_ack, bus1.err}, 32'd0);
    chk("rst_p_rdata", bus1.p_rdata, 32'd0);
    chk("rst_d_rdata", bus1.d_rdata, 32'd0);
    chk("rst_mem_address", bus1.mem_address, 32'd0);
    chk("rst_p_stall", {31'd0, bus1.p_stall}, 32'd0);
    rst_n = 1'b1; rst_n3 = 1'b1; mem_load = 1'b0;
    @(negedge clk);

    // ---- directed vector table ----
    for (int i = 0; i < 10; i++) begin
      do_access(vt[i].src, vt[i].wr, vt[i].addr, vt[i].wdata, r, e, lat, rdc, wrc, side_ok, ok);
      chk($sformatf("vec%0d_done", i), {31'd0, ok}, 32'd1);
      if (ok) begin
        chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
        chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
        chk($sformatf("vec%0d_read_cycles", i), 32'(rdc), (!vt[i].exp_err && !vt[i].wr) ? 32'd1 : 32'd0);
        chk($sformatf("vec%0d_write_cycles", i), 32'(wrc), (!vt[i].exp_err && vt[i].wr) ? 32'd1 : 32'd0);
        chk($sformatf("vec%0d_stall_ports", i), {31'd0, side_ok}, 32'd1);
        if (!vt[i].exp_err && vt[i].wr) ref_write(vt[i].addr, vt[i].wdata);
      end
      @(negedge clk);
    end

    // ---- randomized accesses vs reference model ----
    for (int i = 0; i < 40; i++) begin
      logic s, w, xe;
      logic [31:0] a, wd;
      s  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 104));
      wd = $urandom;
      xe = ref_oob(a);
      exp_q.push_back((xe || w) ? 32'd0 : ref_read(a));
      do_access(s, w, a, wd, r, e, lat, rdc, wrc, side_ok, ok);
      if (!ok) begin
        chk($sformatf("rnd%0d_done", i), {31'd0, ok}, 32'd1);
        void'(exp_q.pop_front());
      end else begin
        chk($sformatf("rnd%0d_rdata", i), r, exp_q.pop_front());
        chk($sformatf("rnd%0d_err", i), {31'd0, e}, {31'd0, xe});
        chk($sformatf("rnd%0d_strobes", i), 32'(rdc + wrc), xe ? 32'd0 : 32'd1);
        if (!xe && w) ref_write(a, wd);
      end
      @(negedge clk);
    end

    // ---- both requesters held: starvation limit ----
    @(negedge clk);
    bus1.p_req = 1'b1; bus1.p_wr = 1'b0; bus1.p_addr = 32'd0;
    bus1.d_req = 1'b1; bus1.d_wr = 1'b0; bus1.d_addr = 32'd4;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(posedge clk); #1;
      if (bus1.p_done && bus1.d_ack) chk("arb_single_winner", 32'd1, 32'd0);
      if (bus1.p_done) begin
        seq.push_back(0); n++;
        chk("arb_p_rdata", bus1.p_rdata, ref_read(32'd0));
      end else if (bus1.d_ack) begin
        seq.push_back(1); n++;
        chk("arb_d_rdata", bus1.d_rdata, ref_read(32'd4));
      end
    end
    bus1.p_req = 1'b0; bus1.d_req = 1'b0;
    chk("arb_completions", 32'(n), 32'd10);
    run = 0;
    for (int i = 0; i < n; i++) begin
      int want;
      want = (run == 4) ? 1 : 0;
      run  = (want == 1) ? 0 : run + 1;
      chk($sformatf("arb_grant%0d", i), 32'(seq[i]), 32'(want));
    end
    repeat (2) @(negedge clk);

    // ---- slow memory: asynchronous abort in the 2nd ACCESS cycle ----
    @(negedge clk);
    bus3.p_req = 1'b1; bus3.p_wr = 1'b0; bus3.p_addr = 32'd8;
    @(posedge clk); #1;
    chk("abort_first_access", 32'(state3), 32'(ACCESS));
    chk("abort_read_before", {31'd0, bus3.mem_read}, 32'd1);
    @(posedge clk); #1;
    rst_n3 = 1'b0;
    #1;
    chk("abort_read_dropped", {31'd0, bus3.mem_read}, 32'd0);
    chk("abort_state_idle", 32'(state3), 32'(IDLE));
    bus3.p_req = 1'b0;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus3.p_done) dn++;
    end
    @(negedge clk);
    rst_n3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus3.p_done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    @(negedge clk);
    bus3.p_req = 1'b1; bus3.p_wr = 1'b0; bus3.p_addr = 32'd8;
    lat = 0; fired = 0;
    for (int c = 0; c < 12 && fired == 0; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bus3.p_done) begin
        fired = 1;
        chk("slow_rdata", bus3.p_rdata, 32'h08090A0B);
      end
    end
    bus3.p_req = 1'b0;
    chk("slow_done", 32'(fired), 32'd1);
    chk("slow_latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
